// File: rtl/instruction_loader_pkg.sv
// Shared definitions for the instruction loader.
// Holds the loader state encoding, the default memory geometry, the default
// end-of-program marker and the byte/word packing constants used when the
// UART byte stream is assembled into instruction words.
package instruction_loader_pkg;

  localparam int          LEN               = 32;
  localparam int          RAM_DEPTH_DEFAULT = 2048;
  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
  localparam int          BYTES_PER_WORD    = 4;
  localparam int          BYTE_W            = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RECEIVE = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } loader_state_e;

  // The processor must be held whenever a load is in progress.
  function automatic logic is_busy_state(input loader_state_e s);
    return (s == ST_RECEIVE) || (s == ST_WRITE);
  endfunction

endpackage

// File: rtl/instruction_loader_if.sv
// Bundle of the loader's control, UART-byte and memory-write signals.
//   in_start        : 1-cycle pulse arming a new load
//   in_rx_data      : byte from the UART receiver
//   in_rx_done      : 1-cycle strobe, in_rx_data valid
//   out_wr_enable   : 1-cycle instruction memory write strobe
//   out_wr_addr     : byte address of the write (multiple of 4)
//   out_wr_data     : assembled instruction word
//   out_word_count  : words written in the current/last load
//   out_busy        : load in progress, CPU held
//   out_load_done   : level, load finished
// The master modport is the environment (UART side, memory, CPU); the slave
// modport is the loader itself.
interface instruction_loader_if #(
  parameter int len = 32
);

  logic           in_start;
  logic [7:0]     in_rx_data;
  logic           in_rx_done;
  logic           out_wr_enable;
  logic [len-1:0] out_wr_addr;
  logic [len-1:0] out_wr_data;
  logic [len-1:0] out_word_count;
  logic           out_busy;
  logic           out_load_done;

  modport master (
    output in_start,
    output in_rx_data,
    output in_rx_done,
    input  out_wr_enable,
    input  out_wr_addr,
    input  out_wr_data,
    input  out_word_count,
    input  out_busy,
    input  out_load_done
  );

  modport slave (
    input  in_start,
    input  in_rx_data,
    input  in_rx_done,
    output out_wr_enable,
    output out_wr_addr,
    output out_wr_data,
    output out_word_count,
    output out_busy,
    output out_load_done
  );

endinterface

// File: rtl/instruction_loader.sv
// Writer side of the instruction memory.
// Assembles the UART byte stream (first byte = MSB) into len-bit words and
// writes them in order into the instruction RAM starting at byte address 0.
// Loading stops after the HALT_WORD has been written or after the last RAM
// word has been filled.
// Ports:
//   clk    : system clock, all logic on posedge
//   reset  : synchronous, active-high; clears state and all outputs
//   bus    : instruction_loader_if.slave (start/rx inputs, write-port and
//            status outputs; see the interface file)
// All outputs are registered and aligned with the FSM state: the write strobe
// is high exactly while the FSM sits in WRITE.
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int             len       = LEN,
  parameter int             RAM_DEPTH = RAM_DEPTH_DEFAULT,
  parameter logic [len-1:0] HALT_WORD = len'(HALT_WORD_DEFAULT)
) (
  input  logic                 clk,
  input  logic                 reset,
  instruction_loader_if.slave  bus
);

  localparam int             IDX_W     = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RAM_DEPTH - 1);
  localparam logic [1:0]     LAST_BYTE = 2'(BYTES_PER_WORD - 1);
  localparam int             ADDR_SHIFT = $clog2(BYTES_PER_WORD);

  loader_state_e    state_q, state_d;
  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic [len-1:0]   shift_q, shift_d;
  logic [IDX_W-1:0] word_idx_q, word_idx_d;
  logic             wr_enable_q, wr_enable_d;
  logic [len-1:0]   wr_addr_q, wr_addr_d;
  logic [len-1:0]   wr_data_q, wr_data_d;
  logic [len-1:0]   word_count_q, word_count_d;
  logic             busy_q, busy_d;
  logic             load_done_q, load_done_d;

  logic             last_byte;
  logic             load_end;

  // The 4th byte of a word is the one accepted while the counter reads 3.
  assign last_byte = bus.in_rx_done && (byte_cnt_q == LAST_BYTE);

  // A load ends once the word just written is the marker or fills the RAM.
  assign load_end = (wr_data_q == HALT_WORD) || (word_idx_q == LAST_IDX);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; in_start is only honoured in IDLE and DONE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (bus.in_start) state_d = ST_RECEIVE;
      ST_RECEIVE: if (last_byte)    state_d = ST_WRITE;
      ST_WRITE:   state_d = load_end ? ST_DONE : ST_RECEIVE;
      ST_DONE:    if (bus.in_start) state_d = ST_RECEIVE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Byte assembler, word index and the write-port values. The write data,
  // address and count are computed on the 4th byte so they are already in
  // their registers during the WRITE cycle, and then held afterwards.
  always_comb begin
    byte_cnt_d   = byte_cnt_q;
    shift_d      = shift_q;
    word_idx_d   = word_idx_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    word_count_d = word_count_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.in_start) begin
          byte_cnt_d   = '0;
          word_idx_d   = '0;
          word_count_d = '0;
        end
      end
      ST_RECEIVE: begin
        if (bus.in_rx_done) begin
          shift_d    = {shift_q[len-BYTE_W-1:0], bus.in_rx_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == LAST_BYTE) begin
            wr_data_d    = shift_d;
            wr_addr_d    = len'(word_idx_q) << ADDR_SHIFT;
            word_count_d = word_count_q + len'(1);
          end
        end
      end
      ST_WRITE: begin
        // A byte arriving during the write cycle is the first byte of the
        // next word, so it must be captured here rather than dropped.
        if (!load_end) begin
          word_idx_d = word_idx_q + IDX_W'(1);
          if (bus.in_rx_done) begin
            shift_d    = {shift_q[len-BYTE_W-1:0], bus.in_rx_data};
            byte_cnt_d = 2'd1;
          end
        end
      end
      default: begin
        byte_cnt_d = '0;
      end
    endcase
  end

  // Status outputs follow the state being entered so that, once registered,
  // they line up with the state itself.
  always_comb begin
    wr_enable_d = (state_d == ST_WRITE);
    busy_d      = is_busy_state(state_d);
    load_done_d = (state_d == ST_DONE);
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_cnt_q   <= '0;
      shift_q      <= '0;
      word_idx_q   <= '0;
      wr_enable_q  <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      word_count_q <= '0;
      busy_q       <= 1'b0;
      load_done_q  <= 1'b0;
    end else begin
      byte_cnt_q   <= byte_cnt_d;
      shift_q      <= shift_d;
      word_idx_q   <= word_idx_d;
      wr_enable_q  <= wr_enable_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      word_count_q <= word_count_d;
      busy_q       <= busy_d;
      load_done_q  <= load_done_d;
    end
  end

  assign bus.out_wr_enable  = wr_enable_q;
  assign bus.out_wr_addr    = wr_addr_q;
  assign bus.out_wr_data    = wr_data_q;
  assign bus.out_word_count = word_count_q;
  assign bus.out_busy       = busy_q;
  assign bus.out_load_done  = load_done_q;

endmodule
